// File: rtl/mp3_feed_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mp3_feed_serializer_pkg
// Description : Shared definitions for the MP3 compressed-data feeder:
//               serializer FSM encoding, FEED_CTRL / FEED_STAT bit positions
//               used by the host register decoder, and the idle levels of
//               the decoder-side serial pins.
// Revision    : 1.0 - initial release
// ============================================================================
package mp3_feed_serializer_pkg;

  // Serializer FSM encoding
  localparam int         c_STATE_W     = 2;
  localparam logic [1:0] c_STATE_IDLE  = 2'd0;
  localparam logic [1:0] c_STATE_LOAD  = 2'd1;
  localparam logic [1:0] c_STATE_SHIFT = 2'd2;

  // Width of one queued word
  localparam int c_WORD_W = 16;

  // FEED_CTRL bit positions
  localparam int c_CTRL_ENABLE_BIT = 0;
  localparam int c_CTRL_FLUSH_BIT  = 1;

  // FEED_STAT bit positions
  localparam int c_STAT_EMPTY_BIT    = 0;
  localparam int c_STAT_FULL_BIT     = 1;
  localparam int c_STAT_OVERFLOW_BIT = 2;
  localparam int c_STAT_BUSY_BIT     = 3;

  // Levels the decoder pins rest at between words
  localparam logic c_IDLE_SDIN = 1'b1;
  localparam logic c_IDLE_BCLK = 1'b1;
  localparam logic c_IDLE_LRCK = 1'b1;

  // Width of a counter that must hold 0..depth inclusive
  function automatic int f_levelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/feed_fifo.sv
`default_nettype none
// ============================================================================
// Module      : feed_fifo
// Description : Synchronous FIFO holding host-written words for the MP3
//               feeder. The head entry is readable combinationally so the
//               serializer can load it in the same cycle it pops.
//               The caller must not push when full unless it also pops.
// Ports       : clock, nReset       - clock, async active-low reset
//               push / pushData     - enqueue a word
//               pop                 - dequeue the head word
//               flush               - empty the FIFO (wins over push/pop)
//               headData            - current head entry
//               level, empty, full  - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module feed_fifo
  import mp3_feed_serializer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     nReset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         headData,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = f_levelWidth(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_LVL_W-1:0] r_level;

  // Storage needs no reset; validity is tracked by the pointers/level.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      r_mem[r_wrPtr] <= pushData;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (push) begin
        r_wrPtr <= r_wrPtr + c_PTR_W'(1);
      end
      if (pop) begin
        r_rdPtr <= r_rdPtr + c_PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign headData = r_mem[r_rdPtr];
  assign level    = r_level;
  assign empty    = (r_level == '0);
  assign full     = (r_level == c_LVL_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/mp3_feed_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mp3_feed_serializer
// Description : Serial feeder for the MP3 decoder compressed-data input.
//               Host words are queued in feed_fifo and shifted MSB-first on
//               sdin/bclk/lrck while enabled and the decoder requests data.
// Ports       : clock, nReset        - system clock, async active-low reset
//               enable, flush        - FEED_CTRL controls (flush is a pulse)
//               writeStrobe/Data     - host word write
//               dataRequest          - decoder request (asynchronous)
//               sdin, bclk, lrck     - decoder serial pins (registered)
//               fifoLevel/Empty/Full - FIFO status
//               overflow             - sticky dropped-write flag
//               busy                 - a word is being loaded or shifted
//               wordCounter          - words fully shifted, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module mp3_feed_serializer
  import mp3_feed_serializer_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int CLOCK_DIV     = 4,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          nReset,
  input  logic                          enable,
  input  logic                          flush,
  input  logic                          writeStrobe,
  input  logic [15:0]                   writeData,
  input  logic                          dataRequest,
  output logic                          sdin,
  output logic                          bclk,
  output logic                          lrck,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
  output logic                          fifoEmpty,
  output logic                          fifoFull,
  output logic                          overflow,
  output logic                          busy,
  output logic [COUNTER_WIDTH-1:0]      wordCounter
);

  localparam int c_DIV_W = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

  logic                     r_reqMeta;
  logic                     r_reqSync;
  logic [c_STATE_W-1:0]     r_state;
  logic [c_WORD_W-1:0]      r_shift;
  logic [3:0]               r_bitIdx;
  logic [c_DIV_W-1:0]       r_divCnt;
  logic                     r_sdin;
  logic                     r_bclk;
  logic                     r_lrck;
  logic                     r_overflow;
  logic [COUNTER_WIDTH-1:0] r_wordCounter;

  logic [c_WORD_W-1:0]      w_head;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_drop;
  logic                     w_startWord;
  logic                     w_phaseEnd;
  logic                     w_wordDone;

  // --------------------------------------------------------------------------
  // Word queue
  // --------------------------------------------------------------------------
  // A full FIFO still accepts a write in the cycle the serializer pops it.
  assign w_pop  = (r_state == c_STATE_LOAD) && !flush;
  assign w_push = writeStrobe && !flush && (!fifoFull || w_pop);
  assign w_drop = writeStrobe && !flush && fifoFull && !w_pop;

  feed_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_WORD_W)
  ) u_fifo (
    .clock    (clock),
    .nReset   (nReset),
    .push     (w_push),
    .pushData (writeData),
    .pop      (w_pop),
    .flush    (flush),
    .headData (w_head),
    .level    (fifoLevel),
    .empty    (fifoEmpty),
    .full     (fifoFull)
  );

  // --------------------------------------------------------------------------
  // dataRequest synchronizer
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_reqMeta <= 1'b0;
      r_reqSync <= 1'b0;
    end else begin
      r_reqMeta <= dataRequest;
      r_reqSync <= r_reqMeta;
    end
  end

  // --------------------------------------------------------------------------
  // Serializer FSM
  // --------------------------------------------------------------------------
  assign w_startWord = enable && r_reqSync && !fifoEmpty;
  assign w_phaseEnd  = (r_divCnt == c_DIV_W'(CLOCK_DIV - 1));
  // The word ends when bit 0's high phase has run its full length.
  assign w_wordDone  = (r_state == c_STATE_SHIFT) && w_phaseEnd &&
                       r_bclk && (r_bitIdx == 4'd0);

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state  <= c_STATE_IDLE;
      r_shift  <= '0;
      r_bitIdx <= '0;
      r_divCnt <= '0;
      r_sdin   <= c_IDLE_SDIN;
      r_bclk   <= c_IDLE_BCLK;
      r_lrck   <= c_IDLE_LRCK;
    end else if (flush) begin
      r_state  <= c_STATE_IDLE;
      r_bitIdx <= '0;
      r_divCnt <= '0;
      r_sdin   <= c_IDLE_SDIN;
      r_bclk   <= c_IDLE_BCLK;
      r_lrck   <= c_IDLE_LRCK;
    end else begin
      case (r_state)
        c_STATE_IDLE: begin
          if (w_startWord) begin
            r_state <= c_STATE_LOAD;
          end
        end

        c_STATE_LOAD: begin
          // r_shift keeps the bits not yet on sdin, next bit in the MSB.
          r_shift  <= {w_head[14:0], 1'b0};
          r_sdin   <= w_head[15];
          r_bclk   <= 1'b0;
          r_lrck   <= 1'b0;
          r_bitIdx <= 4'd15;
          r_divCnt <= '0;
          r_state  <= c_STATE_SHIFT;
        end

        c_STATE_SHIFT: begin
          if (w_phaseEnd) begin
            r_divCnt <= '0;
            if (!r_bclk) begin
              r_bclk <= 1'b1;
            end else if (r_bitIdx == 4'd0) begin
              r_sdin  <= c_IDLE_SDIN;
              r_lrck  <= c_IDLE_LRCK;
              r_state <= c_STATE_IDLE;
            end else begin
              r_bclk   <= 1'b0;
              r_sdin   <= r_shift[15];
              r_shift  <= {r_shift[14:0], 1'b0};
              r_bitIdx <= r_bitIdx - 4'd1;
            end
          end else begin
            r_divCnt <= r_divCnt + c_DIV_W'(1);
          end
        end

        default: begin
          r_state <= c_STATE_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status: word counter and sticky overflow
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_wordCounter <= '0;
      r_overflow    <= 1'b0;
    end else if (flush) begin
      r_wordCounter <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_wordDone) begin
        r_wordCounter <= r_wordCounter + COUNTER_WIDTH'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign sdin        = r_sdin;
  assign bclk        = r_bclk;
  assign lrck        = r_lrck;
  assign overflow    = r_overflow;
  assign busy        = (r_state != c_STATE_IDLE);
  assign wordCounter = r_wordCounter;

endmodule
`default_nettype wire

// File: tb/tb_mp3_feed_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp3_feed_serializer
// Description : Directed self-checking bench for mp3_feed_serializer.
//               dut  : FIFO_DEPTH=8, CLOCK_DIV=4, COUNTER_WIDTH=16
//               dut2 : FIFO_DEPTH=2, CLOCK_DIV=1, COUNTER_WIDTH=4 (wrap test)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mp3_feed_serializer;

  logic        clock = 1'b0;
  logic        nReset = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        writeStrobe = 1'b0;
  logic [15:0] writeData = 16'h0;
  logic        dataRequest = 1'b0;
  logic        sdin, bclk, lrck, fifoEmpty, fifoFull, overflow, busy;
  logic [3:0]  fifoLevel;
  logic [15:0] wordCounter;

  logic        writeStrobe2 = 1'b0;
  logic [15:0] writeData2 = 16'h0;
  logic        sdin2, bclk2, lrck2, fifoEmpty2, fifoFull2, overflow2, busy2;
  logic [1:0]  fifoLevel2;
  logic [3:0]  wordCounter2;

  int checks = 0;
  int errors = 0;

  // Observation of the serial pins of dut
  int          riseCnt = 0;
  logic [15:0] capBits = 16'h0;
  int          cycleCnt = 0;
  int          lowCnt = 0;
  int          fallCnt = 0;
  int          lastFall = 0;
  int          prevFall = 0;
  logic        prevLrck = 1'b1;

  always #5 clock = ~clock;

  mp3_feed_serializer #(.FIFO_DEPTH(8), .CLOCK_DIV(4), .COUNTER_WIDTH(16)) dut (
    .clock(clock), .nReset(nReset), .enable(enable), .flush(flush),
    .writeStrobe(writeStrobe), .writeData(writeData), .dataRequest(dataRequest),
    .sdin(sdin), .bclk(bclk), .lrck(lrck), .fifoLevel(fifoLevel),
    .fifoEmpty(fifoEmpty), .fifoFull(fifoFull), .overflow(overflow),
    .busy(busy), .wordCounter(wordCounter)
  );

  mp3_feed_serializer #(.FIFO_DEPTH(2), .CLOCK_DIV(1), .COUNTER_WIDTH(4)) dut2 (
    .clock(clock), .nReset(nReset), .enable(1'b1), .flush(1'b0),
    .writeStrobe(writeStrobe2), .writeData(writeData2), .dataRequest(1'b1),
    .sdin(sdin2), .bclk(bclk2), .lrck(lrck2), .fifoLevel(fifoLevel2),
    .fifoEmpty(fifoEmpty2), .fifoFull(fifoFull2), .overflow(overflow2),
    .busy(busy2), .wordCounter(wordCounter2)
  );

  // Decoder view: sdin is sampled on each bclk rise.
  always @(posedge bclk) begin
    riseCnt = riseCnt + 1;
    capBits = {capBits[14:0], sdin};
  end

  // Half-cycle sampler: counts lrck-low cycles and timestamps lrck falls.
  always @(negedge clock) begin
    cycleCnt = cycleCnt + 1;
    if (!lrck) lowCnt = lowCnt + 1;
    if (prevLrck && !lrck) begin
      fallCnt  = fallCnt + 1;
      prevFall = lastFall;
      lastFall = cycleCnt;
    end
    prevLrck = lrck;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic write_word(input logic [15:0] d);
    writeData   = d;
    writeStrobe = 1'b1;
    tick();
    writeStrobe = 1'b0;
  endtask

  task automatic write_word2(input logic [15:0] d);
    writeData2   = d;
    writeStrobe2 = 1'b1;
    tick();
    writeStrobe2 = 1'b0;
  endtask

  // Bounded wait for dut wordCounter to reach a value.
  task automatic wait_count(input logic [15:0] target, input int bound, input string name);
    int n;
    n = 0;
    while (wordCounter !== target && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (wordCounter !== target) begin
      errors++;
      $display("FAIL %s: wordCounter %h after %0d cycles, expected %h", name, wordCounter, bound, target);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    tick(3);
    nReset = 1'b1;
    tick(2);
    checks++; if (sdin !== 1'b1) begin errors++; $display("FAIL reset_sdin: got %b expected 1", sdin); end
    checks++; if (bclk !== 1'b1) begin errors++; $display("FAIL reset_bclk: got %b expected 1", bclk); end
    checks++; if (lrck !== 1'b1) begin errors++; $display("FAIL reset_lrck: got %b expected 1", lrck); end
    checks++; if (fifoLevel !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifoLevel); end
    checks++; if (fifoEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", fifoEmpty); end
    checks++; if (fifoFull !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifoFull); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (wordCounter !== 16'h0) begin errors++; $display("FAIL reset_counter: got %h expected 0000", wordCounter); end
  endtask

  task automatic test_single_word();
    int r0, l0;
    enable      = 1'b1;
    dataRequest = 1'b1;
    tick(3);
    r0 = riseCnt;
    l0 = lowCnt;
    write_word(16'hA55A);
    wait_count(16'd1, 300, "single_done");
    tick(2);
    checks++; if (riseCnt - r0 !== 16) begin errors++; $display("FAIL single_rises: got %0d expected 16", riseCnt - r0); end
    checks++; if (capBits !== 16'hA55A) begin errors++; $display("FAIL single_bits: got %h expected a55a", capBits); end
    checks++; if (lowCnt - l0 !== 128) begin errors++; $display("FAIL single_lrck_low: got %0d expected 128", lowCnt - l0); end
    checks++; if (fifoEmpty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", fifoEmpty); end
    checks++; if (lrck !== 1'b1 || bclk !== 1'b1 || sdin !== 1'b1) begin
      errors++; $display("FAIL single_idle_pins: got %b%b%b expected 111", sdin, bclk, lrck); end
  endtask

  task automatic test_overflow();
    enable = 1'b0;
    for (int i = 0; i < 9; i++) write_word(16'h1000 + 16'(i));
    checks++; if (fifoLevel !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d expected 8", fifoLevel); end
    checks++; if (fifoFull !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", fifoFull); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (wordCounter !== 16'd1) begin errors++; $display("FAIL ovf_no_shift_disabled: got %h expected 0001", wordCounter); end
    enable = 1'b1;
    wait_count(16'd9, 1200, "ovf_drain");
    checks++; if (capBits !== 16'h1007) begin errors++; $display("FAIL ovf_last_word: got %h expected 1007", capBits); end
    tick(300);
    checks++; if (wordCounter !== 16'd9) begin errors++; $display("FAIL ovf_ninth_dropped: got %h expected 0009", wordCounter); end
    checks++; if (fifoEmpty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b expected 1", fifoEmpty); end
  endtask

  task automatic test_back_to_back();
    int fc0, s, n;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_flush_ovf: got %b expected 0", overflow); end
    checks++; if (wordCounter !== 16'd0) begin errors++; $display("FAIL b2b_flush_cnt: got %h expected 0000", wordCounter); end
    enable = 1'b0;
    write_word(16'h3C3C);
    write_word(16'h0F0F);
    write_word(16'h8001);
    fc0 = fallCnt;
    enable = 1'b1;
    n = 0;
    while (fallCnt < fc0 + 2 && n < 400) begin tick(); n++; end
    checks++; if (lastFall - prevFall !== 130) begin errors++; $display("FAIL b2b_spacing: got %0d expected 130", lastFall - prevFall); end
    tick(40);
    dataRequest = 1'b0;
    wait_count(16'd2, 200, "b2b_word2_completes");
    checks++; if (capBits !== 16'h0F0F) begin errors++; $display("FAIL b2b_word2_bits: got %h expected 0f0f", capBits); end
    tick(300);
    checks++; if (wordCounter !== 16'd2) begin errors++; $display("FAIL b2b_word3_waits: got %h expected 0002", wordCounter); end
    checks++; if (fifoLevel !== 4'd1) begin errors++; $display("FAIL b2b_word3_queued: got %0d expected 1", fifoLevel); end
    // Request raised just after an edge: sync, sync, LOAD, then lrck falls
    // on the 4th edge, seen by the half-cycle sampler one count later.
    s = cycleCnt;
    dataRequest = 1'b1;
    n = 0;
    while (fallCnt < fc0 + 3 && n < 20) begin tick(); n++; end
    checks++; if (lastFall - s !== 5) begin errors++; $display("FAIL b2b_req_latency: got %0d expected 5", lastFall - s); end
    wait_count(16'd3, 200, "b2b_word3_done");
    checks++; if (capBits !== 16'h8001) begin errors++; $display("FAIL b2b_word3_bits: got %h expected 8001", capBits); end
  endtask

  task automatic test_flush();
    int fc0;
    enable = 1'b0;
    for (int i = 0; i < 9; i++) write_word(16'h4000 + 16'(i));
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_pre_ovf: got %b expected 1", overflow); end
    enable = 1'b1;
    tick(50);
    checks++; if (lrck !== 1'b0) begin errors++; $display("FAIL flush_pre_midword: got lrck %b expected 0", lrck); end
    flush       = 1'b1;
    writeStrobe = 1'b1;
    writeData   = 16'hDEAD;
    tick();
    flush       = 1'b0;
    writeStrobe = 1'b0;
    fc0 = fallCnt;
    checks++; if ({sdin, bclk, lrck} !== 3'b111) begin errors++; $display("FAIL flush_pins: got %b%b%b expected 111", sdin, bclk, lrck); end
    checks++; if (fifoLevel !== 4'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", fifoLevel); end
    checks++; if (wordCounter !== 16'd0) begin errors++; $display("FAIL flush_counter: got %h expected 0000", wordCounter); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf: got %b expected 0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
    tick(200);
    checks++; if (fallCnt !== fc0) begin errors++; $display("FAIL flush_write_dropped: got %0d words started expected 0", fallCnt - fc0); end
    checks++; if (wordCounter !== 16'd0) begin errors++; $display("FAIL flush_idle_counter: got %h expected 0000", wordCounter); end
  endtask

  task automatic test_async_reset();
    int r0, fc0, n;
    r0 = riseCnt;
    write_word(16'h0000);
    n = 0;
    while (riseCnt - r0 < 8 && n < 300) begin tick(); n++; end
    tick(5);  // now in bit 7's low phase
    checks++; if ({sdin, bclk, lrck} !== 3'b000) begin errors++; $display("FAIL rst_pre_pins: got %b%b%b expected 000", sdin, bclk, lrck); end
    #2;
    nReset = 1'b0;
    #1;
    checks++; if ({sdin, bclk, lrck} !== 3'b111) begin errors++; $display("FAIL rst_async_pins: got %b%b%b expected 111", sdin, bclk, lrck); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
    checks++; if (fifoEmpty !== 1'b1) begin errors++; $display("FAIL rst_async_empty: got %b expected 1", fifoEmpty); end
    @(posedge clock);
    #1;
    nReset = 1'b1;
    fc0 = fallCnt;
    tick(200);
    checks++; if (fallCnt !== fc0) begin errors++; $display("FAIL rst_no_resume: got %0d words started expected 0", fallCnt - fc0); end
    checks++; if (wordCounter !== 16'd0) begin errors++; $display("FAIL rst_counter: got %h expected 0000", wordCounter); end
  endtask

  task automatic test_counter_wrap();
    int n;
    for (int i = 1; i <= 15; i++) begin
      write_word2(16'(i));
      n = 0;
      while (wordCounter2 !== 4'(i) && n < 60) begin tick(); n++; end
    end
    checks++; if (wordCounter2 !== 4'hF) begin errors++; $display("FAIL wrap_preload: got %h expected f", wordCounter2); end
    write_word2(16'h5555);
    n = 0;
    while (wordCounter2 === 4'hF && n < 60) begin tick(); n++; end
    checks++; if (wordCounter2 !== 4'h0) begin errors++; $display("FAIL wrap_to_zero: got %h expected 0", wordCounter2); end
    checks++; if (fifoEmpty2 !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", fifoEmpty2); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mp3_feed_serializer.md
# mp3_feed_serializer

Serial feeder for the MP3 decoder's compressed-data input, sitting between the host register decoder (FEED_CTRL/FEED_STAT and the data-write strobe) and the decoder pins mp3InSDIN/mp3InBCLK/mp3InLRCK. Host-written 16-bit words are buffered in a small FIFO and shifted out MSB-first whenever feeding is enabled and the decoder asserts its data-request line. Word count and FIFO status are returned to the register decoder for readback.

## Interface
- FIFO_DEPTH, 8: FIFO entries of 16 bits; power of two, ≥2.
- CLOCK_DIV, 4: clock cycles per BCLK half-period; ≥1.
- COUNTER_WIDTH, 16: width of wordCounter.
- clock  in  1  system clock (29 MHz domain).
- nReset  in  1  reset, asynchronous, active-low.
- enable  in  1  feed enable (FEED_CTRL bit).
- flush  in  1  one-cycle pulse: abort word, empty FIFO, clear counter/flags.
- writeStrobe  in  1  one-cycle pulse; push writeData.
- writeData  in  16  word to queue.
- dataRequest  in  1  decoder data request (mp3StatusDataReq), asynchronous.
- sdin  out  1  serial data to decoder.
- bclk  out  1  bit clock; decoder samples sdin on rising edge.
- lrck  out  1  word frame; low while a word is shifted.
- fifoLevel  out  log2(FIFO_DEPTH)+1  occupied entries.
- fifoEmpty / fifoFull  out  1 each  status.
- overflow  out  1  sticky: a write was dropped.
- busy  out  1  high in LOAD/SHIFT.
- wordCounter  out  COUNTER_WIDTH  words fully shifted, wraps to 0.

## Operation
- Reset values: sdin=1, bclk=1, lrck=1, fifoLevel=0, fifoEmpty=1, fifoFull=0, overflow=0, busy=0, wordCounter=0, state IDLE.
- dataRequest passes through a 2-FF synchronizer (reset to 0); only the synchronized value is used.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE → LOAD when enable & dataReqSync & !fifoEmpty; otherwise hold.
  - LOAD (1 cycle): pop FIFO head into shift register; drive lrck=0, bclk=0, sdin=bit15; bit index=15; → SHIFT.
  - SHIFT: half-period counter counts CLOCK_DIV cycles per phase; bclk rises, then after CLOCK_DIV falls and sdin advances to the next bit. After bit0's high phase completes: lrck=1, bclk stays 1, sdin=1, wordCounter+1, → IDLE.
- dataRequest or enable dropping mid-word does not stop the word; it completes, then IDLE holds.
- FIFO push: writeStrobe & !flush & (!fifoFull | pop this cycle) → accepted. Full with no pop → dropped, overflow=1.
- Simultaneous push and pop: both happen, level unchanged.
- flush: takes effect on the next edge regardless of state: FIFO emptied, wordCounter=0, overflow=0, state IDLE, outputs at idle levels. A write in the same cycle is dropped without setting overflow.
- wordCounter wraps from 2^COUNTER_WIDTH−1 to 0 with no flag.

## Timing
- LOAD follows one cycle after IDLE sees its condition; sdin/bclk/lrck are registered.
- First bclk rise occurs CLOCK_DIV cycles after LOAD; bit k rises at LOAD+(2·(15−k)+1)·CLOCK_DIV.
- lrck returns high LOAD+32·CLOCK_DIV; wordCounter updates on the same edge.
- Back-to-back words: consecutive LOAD cycles are 32·CLOCK_DIV+2 cycles apart.
- dataRequest to first LOAD: 3 cycles minimum (2 sync + IDLE decision).
- fifoLevel/fifoEmpty/fifoFull update on the edge after a push/pop.
- nReset assertion forces reset values immediately, including mid-word; no partial word is resumed.

## Structure
- Shared defines header: FSM state encoding, FEED_CTRL/FEED_STAT bit positions (enable, flush, empty, full, overflow, busy), idle output levels.
- One sub-module: feed_fifo (synchronous FIFO, DEPTH/WIDTH parameters, push/pop/flush, level/empty/full). Serializer FSM, synchronizer and counter live in mp3_feed_serializer.

## Test plan
- Reset, enable=1, dataRequest=1, write 0xA55A → bclk shows 16 rises, sdin sampled at rises = 1010010101011010, lrck low exactly 32·CLOCK_DIV cycles, wordCounter=1, fifoEmpty=1.
- Write 9 words with FIFO_DEPTH=8, enable=0 → fifoLevel=8, fifoFull=1, overflow=1, 9th word never shifted out after enable.
- Queue 3 words, enable, dataRequest held 1 → LOAD spacing 32·CLOCK_DIV+2 cycles, wordCounter=3; drop dataRequest mid-word 2 → word 2 completes, word 3 waits until dataRequest returns.
- flush pulsed mid-word with 4 words queued and writeStrobe same cycle → next cycle sdin=bclk=lrck=1, fifoLevel=0, wordCounter=0, overflow=0.
- nReset asserted at bit 7 of a word → outputs at reset values without waiting for a clock edge; after release nothing is shifted until new data is written.
- Preload wordCounter to 0xFFFF via 65535 words (or forced) then one word → wordCounter=0x0000.
